dmem_read_master: RTL and testbench

Read-only initiator for the `DataMemory` interface: the requesting end of the second data-memory port, whose responder is the block-RAM module's read-only copy port. Accepts word-read requests from the CPU side through a valid/ready handshake and queues them. Issues each request on the `DataMemory` master modport and detects dropped issues, which happen when the responder's primary write port wins that cycle. Retries dropped issues and returns read data through a valid/ready response channel.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_read_master_if.sv | 31 +++
 rtl/dmem_req_fifo.sv | 55 +++++
 rtl/dmem_read_master.sv | 126 ++++++++++++
 tb/tb_dmem_read_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the read-only DataMemory initiator.
// Holds the FSM state encoding, the bus word width and the default reissue limit.
package dmem_pkg;

  localparam int DMEM_WORD_W    = 32;
  localparam int DMEM_MAX_RETRY = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_read_master_if.sv
// DataMemory port: the initiator drives en/we/addr/wd, the responder returns rd/stall.
// stall pulses high for one cycle after an accepted issue, with rd valid alongside it.
interface DataMemory;
  import dmem_pkg::*;

  logic                   en;
  logic                   we;
  logic [DMEM_WORD_W-1:0] addr;
  logic [DMEM_WORD_W-1:0] wd;
  logic [DMEM_WORD_W-1:0] rd;
  logic                   stall;

  modport master (
    output en,
    output we,
    output addr,
    output wd,
    input  rd,
    input  stall
  );

  modport slave (
    input  en,
    input  we,
    input  addr,
    input  wd,
    output rd,
    output stall
  );

endinterface : DataMemory

// File: rtl/dmem_req_fifo.sv
// Circular address queue with power-of-two depth, wrapping pointers and an occupancy count.
// The head entry stays visible until pop; push and pop together leave the count unchanged.
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = DMEM_WORD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers and
  // count decide which entries are meaningful, so clearing it only costs logic.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule : dmem_req_fifo

// File: rtl/dmem_read_master.sv
// Read-only initiator on the second DataMemory port: queues CPU word reads, reissues dropped
// issues and returns data on a valid/ready channel. `DMEM_TIMEOUT_EN bounds reissues at MAX_RETRY.
module dmem_read_master
  import dmem_pkg::*;
#(
  parameter int REQ_DEPTH = 2,
  parameter int MAX_RETRY = DMEM_MAX_RETRY
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DMEM_WORD_W-1:0] req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DMEM_WORD_W-1:0] resp_data,
  output logic                   resp_err,
  output logic                   busy,
  DataMemory.master              port
);

  dmem_state_t            state;
  logic                   q_full;
  logic                   q_empty;
  logic [DMEM_WORD_W-1:0] q_head;
  logic                   push;
  logic                   pop;
  logic                   timeout;
  logic                   pending;

  assign req_ready = ~q_full;
  assign push      = req_valid & req_ready;
  // An accepted issue or a timed-out request retires the head; nothing pops speculatively.
  assign pop       = (state == WAIT) & (port.stall | timeout);
  // Work waiting for the next issue, counting a request arriving this very cycle.
  assign pending   = ~q_empty | push;

  dmem_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .W     (DMEM_WORD_W)
  ) u_req_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (req_addr),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_RETRY + 1);

  logic [CNT_W-1:0] retry_cnt;
  logic             err_q;

  assign timeout  = ~port.stall & (retry_cnt == CNT_W'(MAX_RETRY));
  assign resp_err = err_q;

  // The error flag only moves in WAIT, so it stays frozen across the whole RESP phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retry_cnt <= '0;
      err_q     <= 1'b0;
    end else if (state == WAIT) begin
      if (port.stall) begin
        retry_cnt <= '0;
        err_q     <= 1'b0;
      end else if (timeout) begin
        retry_cnt <= '0;
        err_q     <= 1'b1;
      end else begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_max_retry;

  assign timeout          = 1'b0;
  assign resp_err         = 1'b0;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      resp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) state <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (port.stall) begin
            resp_data <= port.rd;
            state     <= RESP;
          end else if (timeout) begin
            resp_data <= '0;
            state     <= RESP;
          end else begin
            state     <= ISSUE;
          end
        end
        RESP: begin
          if (resp_ready) state <= pending ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode from registered state and queue head only, never from stall/rd.
  assign port.en   = (state == ISSUE);
  assign port.addr = (state == ISSUE) ? q_head : '0;
  assign port.we   = 1'b0;
  assign port.wd   = '0;

  assign resp_valid = (state == RESP);
  assign busy       = ~q_empty | (state != IDLE);

endmodule : dmem_read_master

// File: tb/tb_dmem_read_master.sv
// Directed bench for dmem_read_master: a behavioural DataMemory responder plus a response
// scoreboard fed at stimulus time and drained by an independent monitor.
module tb_dmem_read_master;
  import dmem_pkg::*;

`ifdef DMEM_TIMEOUT_EN
  localparam int TB_MAX_RETRY = 3;
`else
  localparam int TB_MAX_RETRY = DMEM_MAX_RETRY;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  DataMemory mem_bus ();

  dmem_read_master #(
    .REQ_DEPTH (2),
    .MAX_RETRY (TB_MAX_RETRY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .port       (mem_bus.master)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          en_log[$];
  int          drop_until = 0;
  bit          always_drop = 1'b0;
  logic [31:0] mem_arr [256];
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: accepts an issue unless a primary-port write is being modelled for it.
  always @(posedge clock) begin
    if (mem_bus.en === 1'b1) begin
      if (mem_bus.stall !== 1'b1 && !always_drop && en_log.size() >= drop_until) begin
        mem_bus.stall <= 1'b1;
        mem_bus.rd    <= mem_arr[mem_bus.addr[7:0]];
      end else begin
        mem_bus.stall <= 1'b0;
      end
      en_log.push_back(cyc);
    end else begin
      mem_bus.stall <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  // Monitor: checks each accepted response against the scoreboard and holds data stable.
  bit          hold_pending = 1'b0;
  logic [31:0] held_data;
  logic        held_err;

  always @(negedge clock) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else if (resp_valid) begin
      check("no en during RESP", {31'd0, mem_bus.en}, 32'd0);
      if (hold_pending) begin
        check("held resp_data", resp_data, held_data);
        check("held resp_err", {31'd0, resp_err}, {31'd0, held_err});
      end
      if (resp_ready) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected response", {31'd0, resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end else begin
        hold_pending = 1'b1;
        held_data    = resp_data;
        held_err     = resp_err;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_resp(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(output int c);
    int k = 0;
    while (!resp_valid && k < 60) begin
      tick();
      k++;
    end
    check("resp_valid arrives", {31'd0, resp_valid}, 32'd1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 80) begin
      tick();
      k++;
    end
    check("busy drains", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int c;
    int base;

    mem_arr[8'h01] = 32'hA1A1_0001;
    mem_arr[8'h02] = 32'hB2B2_0002;
    mem_arr[8'h03] = 32'hC3C3_0003;
    mem_arr[8'h10] = 32'hDEAD_BEEF;
    mem_arr[8'h20] = 32'h2020_CAFE;
    mem_arr[8'h30] = 32'h3030_0030;
    mem_arr[8'h31] = 32'h3131_0031;
    mem_arr[8'h40] = 32'h4040_0040;

    // Reset values while held in reset.
    repeat (3) @(posedge clock);
    #1;
    check("reset en", {31'd0, mem_bus.en}, 32'd0);
    check("reset we", {31'd0, mem_bus.we}, 32'd0);
    check("reset addr", mem_bus.addr, 32'd0);
    check("reset wd", mem_bus.wd, 32'd0);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Single read, no drops: one en pulse, response 3 cycles after the handshake.
    resp_ready = 1'b1;
    base = en_log.size();
    req_valid = 1'b1;
    req_addr  = 32'h10;
    n = cyc;
    expect_resp(32'hDEAD_BEEF, 1'b0);
    tick();
    req_valid = 1'b0;
    check("t1 issue addr", mem_bus.addr, 32'h10);
    wait_resp(c);
    check("t1 latency", c - n, 32'd3);
    check("t1 en pulses", en_log.size() - base, 32'd1);
    wait_idle();

    // Two issues lost to primary-port writes: three en pulses 2 cycles apart, latency 7.
    base = en_log.size();
    drop_until = base + 2;
    req_valid = 1'b1;
    req_addr  = 32'h20;
    n = cyc;
    expect_resp(32'h2020_CAFE, 1'b0);
    tick();
    req_valid = 1'b0;
    wait_resp(c);
    check("t2 latency", c - n, 32'd7);
    check("t2 en pulses", en_log.size() - base, 32'd3);
    if (en_log.size() - base == 3) begin
      check("t2 spacing 0-1", en_log[base+1] - en_log[base], 32'd2);
      check("t2 spacing 1-2", en_log[base+2] - en_log[base+1], 32'd2);
    end
    wait_idle();

    // Three back-to-back requests with the first response stalled 5 cycles.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h1;
    expect_resp(32'hA1A1_0001, 1'b0);
    tick();
    req_addr = 32'h2;
    expect_resp(32'hB2B2_0002, 1'b0);
    tick();
    check("t3 full after two", {31'd0, req_ready}, 32'd0);
    req_addr = 32'h3;
    expect_resp(32'hC3C3_0003, 1'b0);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("t3 third accepted", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    wait_resp(c);
    repeat (5) tick();
    resp_ready = 1'b1;
    wait_idle();

    // Request and response handshakes in the same cycle: next en follows immediately.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h30;
    expect_resp(32'h3030_0030, 1'b0);
    tick();
    req_valid = 1'b0;
    wait_resp(c);
    req_valid  = 1'b1;
    req_addr   = 32'h31;
    resp_ready = 1'b1;
    expect_resp(32'h3131_0031, 1'b0);
    tick();
    req_valid = 1'b0;
    check("t6 en next cycle", {31'd0, mem_bus.en}, 32'd1);
    check("t6 addr next cycle", mem_bus.addr, 32'h31);
    check("t6 one entry left", {31'd0, req_ready}, 32'd1);
    wait_idle();

`ifdef DMEM_TIMEOUT_EN
    // Responder always dropping: MAX_RETRY+1 issues, then an error response.
    always_drop = 1'b1;
    base = en_log.size();
    req_valid = 1'b1;
    req_addr  = 32'h40;
    expect_resp(32'h0, 1'b1);
    tick();
    req_valid = 1'b0;
    wait_resp(c);
    check("t4 en pulses", en_log.size() - base, 32'd4);
    tick();
    always_drop = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    expect_resp(32'hDEAD_BEEF, 1'b0);
    tick();
    req_valid = 1'b0;
    wait_idle();
`endif

    // Reset in WAIT with a second request queued; the late stall must be ignored.
    req_valid = 1'b1;
    req_addr  = 32'h1;
    tick();
    req_addr = 32'h2;
    tick();
    req_valid = 1'b0;
    check("t5 busy before reset", {31'd0, busy}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("t5 async en", {31'd0, mem_bus.en}, 32'd0);
    check("t5 async addr", mem_bus.addr, 32'd0);
    check("t5 async resp_valid", {31'd0, resp_valid}, 32'd0);
    check("t5 async resp_data", resp_data, 32'd0);
    check("t5 async resp_err", {31'd0, resp_err}, 32'd0);
    check("t5 async busy", {31'd0, busy}, 32'd0);
    check("t5 async req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    #1;
    reset = 1'b1;
    base = en_log.size();
    repeat (8) tick();
    check("t5 no response", {31'd0, resp_valid}, 32'd0);
    check("t5 idle", {31'd0, busy}, 32'd0);
    check("t5 no issue", en_log.size() - base, 32'd0);

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dmem_read_master
